cpu_boot_loader: RTL and testbench
==================================

Name: cpu_boot_loader

Overview:
- Upstream feeder of the cpu top. It accepts a 32-bit word stream from the test or host interface and writes a program image into instruction memory through the cpu's external port (addr_ext/wen_ext/wdata_ext).
- It writes the data image into data memory through the second external port (addr_ext_2/wen_ext_2/wdata_ext_2).
- It then raises the cpu enable for a bounded number of cycles and reports completion.
- It is the only driver of the cpu's enable and external write ports during normal operation.

Parameters:
- IMEM_AW, 9, instruction-memory word-address width; capacity 2^IMEM_AW words.
- DMEM_AW, 10, data-memory word-address width; capacity 2^DMEM_AW words.
- ADDR_SHIFT, 2, left shift applied to the word index to form the byte address driven on the external address ports.

Ports:
- clk  in  1  main clock
- arst  in  1  asynchronous reset, active-high
- start  in  1  single-cycle pulse; begins a load-and-run session
- run_cycles  in  32  number of cycles cpu_enable stays high; 0 means run until halt
- halt  in  1  terminates RUN early
- s_valid  in  1  stream word valid
- s_data  in  32  stream word
- s_ready  out  1  stream word accepted when s_valid&&s_ready
- imem_addr  out  32  to cpu addr_ext
- imem_wen  out  1  to cpu wen_ext
- imem_wdata  out  32  to cpu wdata_ext
- dmem_addr  out  32  to cpu addr_ext_2
- dmem_wen  out  1  to cpu wen_ext_2
- dmem_wdata  out  32  to cpu wdata_ext_2
- cpu_enable  out  1  to cpu enable
- busy  out  1  high in any state except IDLE, DONE, ERROR
- done  out  1  high in DONE
- error  out  1  high in ERROR
- cycle_count  out  32  cycles elapsed in RUN; held after RUN

Behaviour:
- Reset values: every output is 0; state is IDLE; all counters are 0. Reset asserted mid-session aborts immediately: cpu_enable and both wen fall asynchronously.
- States and transitions:
  - IDLE -> HDR on start.
  - HDR: s_ready=1. On handshake, latch n_instr=s_data[15:0] and n_data=s_data[31:16].
    - If n_instr > 2^IMEM_AW or n_data > 2^DMEM_AW -> ERROR.
    - Else if n_instr != 0 -> LOAD_I; else if n_data != 0 -> LOAD_D; else -> RUN.
  - LOAD_I: s_ready=1. Each handshake registers imem_wdata=s_data, imem_addr=idx<<ADDR_SHIFT, and imem_wen=1 for exactly the following cycle. idx increments per handshake. After word n_instr-1: clear idx and go to LOAD_D if n_data != 0, else RUN.
  - LOAD_D: same rules on the dmem_* outputs. After the last word -> RUN (or CHECK when the optional feature is enabled).
  - RUN: cpu_enable=1 (registered) and cycle_count increments each cycle. Exit to DONE when cycle_count reaches run_cycles (run_cycles != 0) or when halt=1; halt has priority. cpu_enable rises one cycle after entry to RUN and falls on the DONE entry edge.
  - DONE / ERROR: start re-enters HDR; cycle_count clears on that start.
- Latency and stream timing:
  - Write latency is 1 cycle from handshake to wen.
  - Back-to-back handshakes give one write per cycle with no bubbles.
  - s_valid low inserts gaps; wen is low in gap cycles.
- s_ready is 0 in IDLE, RUN, DONE and ERROR; s_valid there is ignored and nothing is consumed.
- start is ignored while busy.
- The index counter is IMEM_AW+1 or DMEM_AW+1 bits so that a count equal to full capacity does not wrap. The last write lands at address (2^AW-1)<<ADDR_SHIFT.
- Stream payload is word-count driven only; no terminator word exists.
- imem_wen and dmem_wen are never high in the same cycle. Both are 0 whenever cpu_enable=1.

Optional Feature:
- Macro: BOOT_LOADER_CHECKSUM_EN.
- Defined:
  - The loader keeps a running 32-bit XOR of all payload words (instruction then data; header excluded).
  - After the last payload word the FSM enters CHECK with s_ready=1 and accepts one extra word.
  - Equal to the accumulated XOR -> RUN; mismatch -> ERROR with cpu_enable never asserted.
  - With n_instr=n_data=0 the expected word is 0.
- Undefined: no CHECK state and no extra word; the load goes straight to RUN.

Decomposition:
- Shared package boot_loader_pkg:
  - state enum (IDLE, HDR, LOAD_I, LOAD_D, CHECK, RUN, DONE, ERROR)
  - header field constants: HDR_NI_LSB=0, HDR_ND_LSB=16, HDR_FIELD_W=16
  - default memory widths
- One natural sub-module: boot_write_port, instantiated twice (imem and dmem). It holds the index counter, address shift and registered wen/wdata generation, driven by a load-enable and handshake from the FSM.

Test Plan:
- Header 0x0002_0003, instruction words 0xA0..0xA2 and data words 0xD0,0xD1 back-to-back, run_cycles=10 -> imem writes at addresses 0,4,8 and dmem writes at 0,4, one per cycle; cpu_enable high for exactly 10 cycles; done=1; cycle_count=10.
- Header 0x0000_0200 (512 instructions, full IMEM) with s_valid toggling every other cycle -> 512 writes, last address 0x7FC, no wrap, no dmem writes, wen low in gap cycles.
- Header 0x0000_0201 -> ERROR after the header; no wen pulses; s_ready=0 afterwards.
- run_cycles=0 with halt pulsed 25 cycles into RUN -> DONE, cycle_count=25, cpu_enable low the next cycle.
- arst asserted mid LOAD_D after 3 of 5 words -> all outputs 0 immediately; a new start after release reloads from header cleanly.
- With BOOT_LOADER_CHECKSUM_EN, payload 0x1,0x2 with check word 0x3 -> RUN; check word 0x4 -> ERROR, cpu_enable never high.

Source files
------------

// File: rtl/boot_loader_pkg.sv
`default_nettype none
// ============================================================================
// boot_loader_pkg: shared state encoding, header layout and default memory
// geometry for the cpu boot loader.
// Revision: 1.0
// ============================================================================
package boot_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR    = 3'd1,
    LOAD_I = 3'd2,
    LOAD_D = 3'd3,
    CHECK  = 3'd4,
    RUN    = 3'd5,
    DONE   = 3'd6,
    ERROR  = 3'd7
  } state_e;

  localparam int HDR_NI_LSB  = 0;
  localparam int HDR_ND_LSB  = 16;
  localparam int HDR_FIELD_W = 16;

  localparam int DEF_IMEM_AW    = 9;
  localparam int DEF_DMEM_AW    = 10;
  localparam int DEF_ADDR_SHIFT = 2;

endpackage
`default_nettype wire

// File: rtl/boot_write_port.sv
`default_nettype none
// ============================================================================
// boot_write_port: word-index counter plus registered addr/wen/wdata for one
// external memory write port of the boot loader.
// Revision: 1.0
// ============================================================================
module boot_write_port
  import boot_loader_pkg::*;
#(
  parameter int AW         = DEF_IMEM_AW,
  parameter int ADDR_SHIFT = DEF_ADDR_SHIFT
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   clr_i,
  input  logic                   load_i,
  input  logic [HDR_FIELD_W-1:0] count_i,
  input  logic [31:0]            data_i,
  output logic                   last_o,
  output logic [31:0]            addr_o,
  output logic                   wen_o,
  output logic [31:0]            wdata_o
);

  // One spare bit so a full-capacity count never wraps the index.
  logic [AW:0]   idx_q, idx_d;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          wen_q;

  assign last_o = ((HDR_FIELD_W+1)'(idx_q) + (HDR_FIELD_W+1)'(1)) == {1'b0, count_i};

  always_comb begin
    idx_d = idx_q;
    if (clr_i || (load_i && last_o)) begin
      idx_d = '0;
    end else if (load_i) begin
      idx_d = idx_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
    end else begin
      idx_q <= idx_d;
      wen_q <= load_i;
      if (load_i) begin
        addr_q  <= 32'(idx_q) << ADDR_SHIFT;
        wdata_q <= data_i;
      end
    end
  end

  assign addr_o  = addr_q;
  assign wen_o   = wen_q;
  assign wdata_o = wdata_q;

endmodule
`default_nettype wire

// File: rtl/cpu_boot_loader.sv
`default_nettype none
// ============================================================================
// cpu_boot_loader: loads a streamed program and data image into the cpu
// memories, then enables the cpu for a bounded number of cycles.
// Option macro BOOT_LOADER_CHECKSUM_EN: trailing XOR check word before RUN.
// Revision: 1.0
// ============================================================================
module cpu_boot_loader
  import boot_loader_pkg::*;
#(
  parameter int IMEM_AW    = DEF_IMEM_AW,
  parameter int DMEM_AW    = DEF_DMEM_AW,
  parameter int ADDR_SHIFT = DEF_ADDR_SHIFT
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        start,
  input  logic [31:0] run_cycles,
  input  logic        halt,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic [31:0] imem_addr,
  output logic        imem_wen,
  output logic [31:0] imem_wdata,
  output logic [31:0] dmem_addr,
  output logic        dmem_wen,
  output logic [31:0] dmem_wdata,
  output logic        cpu_enable,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] cycle_count
);

  localparam logic [HDR_FIELD_W:0] IMEM_CAP = (HDR_FIELD_W+1)'(1 << IMEM_AW);
  localparam logic [HDR_FIELD_W:0] DMEM_CAP = (HDR_FIELD_W+1)'(1 << DMEM_AW);
`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam state_e LOAD_END = CHECK;
`else
  localparam state_e LOAD_END = RUN;
`endif

  state_e                 state_q, state_d;
  logic [HDR_FIELD_W-1:0] n_instr_q, n_data_q;
  logic [31:0]            cycle_count_q, cycle_count_d;
  logic                   cpu_enable_q;
  logic [HDR_FIELD_W-1:0] hdr_ni, hdr_nd;
  logic                   i_load, d_load, i_last, d_last, idx_clr;

  assign hdr_ni = s_data[HDR_NI_LSB +: HDR_FIELD_W];
  assign hdr_nd = s_data[HDR_ND_LSB +: HDR_FIELD_W];

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [31:0] xsum_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      xsum_q <= '0;
    end else if (state_q == HDR) begin
      xsum_q <= '0;
    end else if (i_load || d_load) begin
      xsum_q <= xsum_q ^ s_data;
    end
  end
`endif

  always_comb begin
    state_d       = state_q;
    s_ready       = 1'b0;
    cycle_count_d = cycle_count_q;
    case (state_q)
      IDLE: if (start) state_d = HDR;
      HDR: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (({1'b0, hdr_ni} > IMEM_CAP) || ({1'b0, hdr_nd} > DMEM_CAP)) state_d = ERROR;
          else if (hdr_ni != '0) state_d = LOAD_I;
          else if (hdr_nd != '0) state_d = LOAD_D;
          else                   state_d = LOAD_END;
        end
      end
      LOAD_I: begin
        s_ready = 1'b1;
        if (s_valid && i_last) state_d = (n_data_q != '0) ? LOAD_D : LOAD_END;
      end
      LOAD_D: begin
        s_ready = 1'b1;
        if (s_valid && d_last) state_d = LOAD_END;
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      CHECK: begin
        s_ready = 1'b1;
        if (s_valid) state_d = (s_data == xsum_q) ? RUN : ERROR;
      end
`endif
      RUN: begin
        if (halt)                                                    state_d = DONE;
        else if ((run_cycles != '0) && (cycle_count_q == run_cycles)) state_d = DONE;
        else                                                         cycle_count_d = cycle_count_q + 32'd1;
      end
      DONE, ERROR: begin
        if (start) begin
          state_d       = HDR;
          cycle_count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Enable is set only while RUN persists, so it trails RUN entry by a cycle
  // and drops on the same edge that enters DONE.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q       <= IDLE;
      n_instr_q     <= '0;
      n_data_q      <= '0;
      cycle_count_q <= '0;
      cpu_enable_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cycle_count_q <= cycle_count_d;
      cpu_enable_q  <= (state_q == RUN) && (state_d == RUN);
      if ((state_q == HDR) && s_valid) begin
        n_instr_q <= hdr_ni;
        n_data_q  <= hdr_nd;
      end
    end
  end

  assign i_load  = (state_q == LOAD_I) && s_valid;
  assign d_load  = (state_q == LOAD_D) && s_valid;
  assign idx_clr = (state_q == HDR);

  boot_write_port #(.AW(IMEM_AW), .ADDR_SHIFT(ADDR_SHIFT)) u_imem_port (
    .clk     (clk),
    .arst    (arst),
    .clr_i   (idx_clr),
    .load_i  (i_load),
    .count_i (n_instr_q),
    .data_i  (s_data),
    .last_o  (i_last),
    .addr_o  (imem_addr),
    .wen_o   (imem_wen),
    .wdata_o (imem_wdata)
  );

  boot_write_port #(.AW(DMEM_AW), .ADDR_SHIFT(ADDR_SHIFT)) u_dmem_port (
    .clk     (clk),
    .arst    (arst),
    .clr_i   (idx_clr),
    .load_i  (d_load),
    .count_i (n_data_q),
    .data_i  (s_data),
    .last_o  (d_last),
    .addr_o  (dmem_addr),
    .wen_o   (dmem_wen),
    .wdata_o (dmem_wdata)
  );

  assign cpu_enable  = cpu_enable_q;
  assign cycle_count = cycle_count_q;
  assign busy        = !((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
  assign done        = (state_q == DONE);
  assign error       = (state_q == ERROR);

endmodule
`default_nettype wire

// File: tb/tb_cpu_boot_loader.sv
`default_nettype none
// ============================================================================
// tb_cpu_boot_loader: scoreboard bench for cpu_boot_loader; expected writes
// are queued as payload words are driven and popped as wen pulses appear.
// Revision: 1.0
// ============================================================================
module tb_cpu_boot_loader;

  logic        clk = 1'b0;
  logic        arst;
  logic        start;
  logic [31:0] run_cycles;
  logic        halt;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic [31:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata, cycle_count;
  logic        imem_wen, dmem_wen, cpu_enable, busy, done, error;

  cpu_boot_loader dut (
    .clk (clk), .arst (arst), .start (start), .run_cycles (run_cycles),
    .halt (halt), .s_valid (s_valid), .s_data (s_data), .s_ready (s_ready),
    .imem_addr (imem_addr), .imem_wen (imem_wen), .imem_wdata (imem_wdata),
    .dmem_addr (dmem_addr), .dmem_wen (dmem_wen), .dmem_wdata (dmem_wdata),
    .cpu_enable (cpu_enable), .busy (busy), .done (done), .error (error),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_d;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb[$];
  wr_t         exp_w, act_w;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc = 0;
  int          wr_count = 0, d_count = 0, en_cycles = 0;
  int          first_wr_cyc = 0, last_wr_cyc = 0;
  logic [31:0] last_addr = '0;

  // Monitor: pops the scoreboard on every write and watches port exclusivity.
  always @(negedge clk) begin
    cyc++;
    if (!arst) begin
      if (cpu_enable) en_cycles++;
      if (imem_wen || dmem_wen) begin
        n_tests++;
        if ((imem_wen && dmem_wen) || cpu_enable) begin
          n_fail++;
          $display("FAIL wen_exclusive: imem_wen=%0b dmem_wen=%0b cpu_enable=%0b, required at most one wen and no enable",
                   imem_wen, dmem_wen, cpu_enable);
        end
        wr_count++;
        if (dmem_wen) d_count++;
        if (wr_count == 1) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        act_w.is_d = dmem_wen;
        act_w.addr = dmem_wen ? dmem_addr : imem_addr;
        act_w.data = dmem_wen ? dmem_wdata : imem_wdata;
        last_addr  = act_w.addr;
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got is_d=%0b addr=%h data=%h, required no write",
                   act_w.is_d, act_w.addr, act_w.data);
        end else begin
          exp_w = sb.pop_front();
          if (act_w !== exp_w) begin
            n_fail++;
            $display("FAIL write: got is_d=%0b addr=%h data=%h, required is_d=%0b addr=%h data=%h",
                     act_w.is_d, act_w.addr, act_w.data, exp_w.is_d, exp_w.addr, exp_w.data);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_stats();
    wr_count = 0; d_count = 0; en_cycles = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w, input int gap);
    int t;
    repeat (gap) begin s_valid = 1'b0; @(posedge clk); #1; end
    s_valid = 1'b1;
    s_data  = w;
    t = 0;
    while (!s_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) begin
      n_tests++; n_fail++;
      $display("FAIL push_word: s_ready=0 for 50 cycles, required 1");
    end else begin
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic load_payload(input int ni, input int nd, input int gap);
    logic [31:0] w;
    logic [31:0] xs;
    xs = '0;
    for (int i = 0; i < ni; i++) begin
      w = 32'h0000_00A0 + 32'(i);
      xs ^= w;
      sb.push_back('{1'b0, 32'(i * 4), w});
      push_word(w, gap);
    end
    for (int i = 0; i < nd; i++) begin
      w = 32'h0000_00D0 + 32'(i);
      xs ^= w;
      sb.push_back('{1'b1, 32'(i * 4), w});
      push_word(w, gap);
    end
`ifdef BOOT_LOADER_CHECKSUM_EN
    push_word(xs, 0);
`endif
  endtask

  task automatic wait_done(input int max);
    int t;
    t = 0;
    while (!done && !error && t < max) begin @(posedge clk); #1; t++; end
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_done: done=%0b error=%0b, required done=1", done, error);
    end
  endtask

  task automatic check_sb_empty(input string name);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s sb_empty: %0d writes outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    #1;
    s_valid = 1'b1;
    n_tests++;
    if ({imem_wen, dmem_wen, cpu_enable, s_ready, busy, done, error} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 0000000",
               {imem_wen, dmem_wen, cpu_enable, s_ready, busy, done, error});
    end
    n_tests++;
    if ({imem_addr, imem_wdata, dmem_addr, dmem_wdata, cycle_count} !== 160'b0) begin
      n_fail++;
      $display("FAIL reset_buses: imem_addr=%h dmem_addr=%h cycle_count=%h, required 0",
               imem_addr, dmem_addr, cycle_count);
    end
    @(posedge clk); #1;
    arst = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_tests++;
    if (s_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignore: s_ready=%0b busy=%0b, required 0 0", s_ready, busy);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_basic();
    clear_stats();
    run_cycles = 32'd10;
    pulse_start();
    push_word(32'h0002_0003, 0);
    load_payload(3, 2, 0);
    wait_done(200);
    n_tests++;
    if (cycle_count !== 32'd10 || en_cycles != 10) begin
      n_fail++;
      $display("FAIL basic_run: cycle_count=%0d enable_cycles=%0d, required 10 10", cycle_count, en_cycles);
    end
    n_tests++;
    if (wr_count != 5 || (last_wr_cyc - first_wr_cyc) != 4) begin
      n_fail++;
      $display("FAIL basic_b2b: writes=%0d span=%0d, required 5 4", wr_count, last_wr_cyc - first_wr_cyc);
    end
    check_sb_empty("basic");
  endtask

  task automatic test_full_imem_gaps();
    clear_stats();
    run_cycles = 32'd3;
    pulse_start();
    n_tests++;
    if (cycle_count !== 32'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_clear: cycle_count=%0d busy=%0b, required 0 1", cycle_count, busy);
    end
    push_word(32'h0000_0200, 0);
    load_payload(512, 0, 1);
    wait_done(200);
    n_tests++;
    if (wr_count != 512 || d_count != 0 || last_addr !== 32'h0000_07FC) begin
      n_fail++;
      $display("FAIL full_imem: writes=%0d dmem_writes=%0d last_addr=%h, required 512 0 000007fc",
               wr_count, d_count, last_addr);
    end
    check_sb_empty("full_imem");
  endtask

  task automatic test_hdr_error();
    clear_stats();
    pulse_start();
    push_word(32'h0000_0201, 0);
    s_valid = 1'b1;
    s_data  = 32'h1234_5678;
    #1;
    n_tests++;
    if (error !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hdr_error: error=%0b s_ready=%0b busy=%0b, required 1 0 0", error, s_ready, busy);
    end
    repeat (4) @(posedge clk); #1;
    n_tests++;
    if (wr_count != 0 || error !== 1'b1 || en_cycles != 0) begin
      n_fail++;
      $display("FAIL hdr_error_hold: writes=%0d error=%0b enable_cycles=%0d, required 0 1 0",
               wr_count, error, en_cycles);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_halt();
    int t;
    clear_stats();
    run_cycles = 32'd0;
    pulse_start();
    push_word(32'h0001_0001, 0);
    load_payload(1, 1, 0);
    t = 0;
    while (cycle_count !== 32'd25 && t < 200) begin @(posedge clk); #1; t++; end
    n_tests++;
    if (cycle_count !== 32'd25 || cpu_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_reach: cycle_count=%0d cpu_enable=%0b, required 25 1", cycle_count, cpu_enable);
    end
    halt = 1'b1;
    @(posedge clk); #1;
    halt = 1'b0;
    n_tests++;
    if (done !== 1'b1 || cycle_count !== 32'd25 || cpu_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_stop: done=%0b cycle_count=%0d cpu_enable=%0b, required 1 25 0",
               done, cycle_count, cpu_enable);
    end
    repeat (3) @(posedge clk); #1;
    n_tests++;
    if (cycle_count !== 32'd25) begin
      n_fail++;
      $display("FAIL halt_hold: cycle_count=%0d, required 25", cycle_count);
    end
    check_sb_empty("halt");
  endtask

  task automatic test_arst_reload();
    clear_stats();
    run_cycles = 32'd4;
    pulse_start();
    push_word(32'h0005_0002, 0);
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{1'b0, 32'(i * 4), 32'h0000_00A0 + 32'(i)});
      push_word(32'h0000_00A0 + 32'(i), 0);
    end
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{1'b1, 32'(i * 4), 32'h0000_00D0 + 32'(i)});
      push_word(32'h0000_00D0 + 32'(i), 0);
    end
    arst = 1'b1;
    #1;
    n_tests++;
    if ({imem_wen, dmem_wen, cpu_enable, s_ready, busy, done, error} !== 7'b0 ||
        {imem_addr, imem_wdata, dmem_addr, dmem_wdata, cycle_count} !== 160'b0) begin
      n_fail++;
      $display("FAIL arst_abort: flags=%b dmem_addr=%h dmem_wdata=%h, required all 0",
               {imem_wen, dmem_wen, cpu_enable, s_ready, busy, done, error}, dmem_addr, dmem_wdata);
    end
    sb.delete();
    @(posedge clk); #1;
    arst = 1'b0;
    n_tests++;
    if (wr_count != 4) begin
      n_fail++;
      $display("FAIL arst_partial: writes=%0d, required 4", wr_count);
    end
    clear_stats();
    pulse_start();
    push_word(32'h0002_0003, 0);
    load_payload(3, 2, 0);
    wait_done(200);
    n_tests++;
    if (cycle_count !== 32'd4 || en_cycles != 4 || wr_count != 5) begin
      n_fail++;
      $display("FAIL arst_reload: cycle_count=%0d enable_cycles=%0d writes=%0d, required 4 4 5",
               cycle_count, en_cycles, wr_count);
    end
    check_sb_empty("arst_reload");
  endtask

`ifdef BOOT_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    clear_stats();
    run_cycles = 32'd2;
    pulse_start();
    push_word(32'h0001_0001, 0);
    sb.push_back('{1'b0, 32'd0, 32'h1});
    push_word(32'h1, 0);
    sb.push_back('{1'b1, 32'd0, 32'h2});
    push_word(32'h2, 0);
    push_word(32'h3, 0);
    wait_done(100);
    n_tests++;
    if (en_cycles != 2) begin
      n_fail++;
      $display("FAIL checksum_good: enable_cycles=%0d, required 2", en_cycles);
    end
    clear_stats();
    pulse_start();
    push_word(32'h0001_0001, 0);
    sb.push_back('{1'b0, 32'd0, 32'h1});
    push_word(32'h1, 0);
    sb.push_back('{1'b1, 32'd0, 32'h2});
    push_word(32'h2, 0);
    push_word(32'h4, 0);
    repeat (5) @(posedge clk); #1;
    n_tests++;
    if (error !== 1'b1 || en_cycles != 0 || cpu_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL checksum_bad: error=%0b enable_cycles=%0d, required 1 0", error, en_cycles);
    end
    check_sb_empty("checksum");
  endtask
`endif

  initial begin
    arst = 1'b1; start = 1'b0; run_cycles = '0; halt = 1'b0;
    s_valid = 1'b0; s_data = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_basic();
    test_full_imem_gaps();
    test_hdr_error();
    test_halt();
    test_arst_reload();
`ifdef BOOT_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
